simon_core: RTL and testbench

- Parametrised Simon game engine: next generation of the fixed 4-button game controller.
- Generalised to NUM_BUTTONS lamps/buttons and DEPTH rounds, with internal sequence memory, configurable show/gap timing in timer pulses, and a persistent high-score register.
- Sits between the input sync/encode block, the LFSR rng, the pulse timer and the lamp decoder at top level.

---
 rtl/simon_pkg.sv | 32 +++
 rtl/simon_core_seq_mem.sv | 29 ++
 rtl/simon_core.sv | 225 ++++++++++++++++++++++
 tb/tb_simon_core.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game engine.
package simon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHOW,
        S_GAP,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    localparam int unsigned SIMON_NUM_BUTTONS    = 4;
    localparam int unsigned SIMON_DEPTH          = 16;
    localparam int unsigned SIMON_ON_PULSES      = 2;
    localparam int unsigned SIMON_GAP_PULSES     = 1;
    localparam int unsigned SIMON_TIMEOUT_PULSES = 8;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_core_seq_mem.sv
// Sequence storage: DEPTH x WIDTH register array, one synchronous write
// port and one combinational read port. The array is not reset.
module simon_seq_mem
    import simon_pkg::*;
#(
    parameter int unsigned DEPTH = SIMON_DEPTH,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Capture one sequence element per ADD cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_core.sv
// Simon game engine: grows a random lamp sequence one step per round, plays
// it back using external timer pulses, then checks the player's presses.
// Optional build macro SIMON_INPUT_TIMEOUT_EN adds a player-inactivity
// timeout in WAIT_IN.
module simon_core
    import simon_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS    = SIMON_NUM_BUTTONS,
    parameter int unsigned DEPTH          = SIMON_DEPTH,
    parameter int unsigned ON_PULSES      = SIMON_ON_PULSES,
    parameter int unsigned GAP_PULSES     = SIMON_GAP_PULSES,
    parameter int unsigned TIMEOUT_PULSES = SIMON_TIMEOUT_PULSES,
    localparam int unsigned BW = width_of(NUM_BUTTONS),
    localparam int unsigned LW = width_of(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [BW-1:0] RAND,
    input  logic [BW-1:0] IN,
    input  logic          IN_VALID,
    input  logic          TIMER_PULSE,
    output logic          TIMER_GO,
    output logic [BW-1:0] OUT,
    output logic          OUT_ENA,
    output logic [LW-1:0] LEVEL,
    output logic [LW-1:0] HS_SCORE,
    output logic          HS,
    output logic          WIN,
    output logic          LOSE,
    output logic          BUSY
);

    localparam int unsigned CW = width_of(max3(ON_PULSES, GAP_PULSES, TIMEOUT_PULSES));
    localparam int unsigned MW = width_of(DEPTH);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          go_q, go_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic          hs_q, hs_d;
    logic [LW-1:0] hs_score_q, hs_score_d;
    logic [BW-1:0] out_hold_q;

    logic          seq_we;
    logic [BW-1:0] seq_rd;
    logic [BW-1:0] rand_red;
    logic          pulse_v;
    logic          last_step;
    logic          press_ok;
    logic [LW-1:0] score;

    // A pulse landing in the timer-restart cycle belongs to the old count.
    assign pulse_v   = TIMER_PULSE & ~go_q;
    assign last_step = (idx_q == len_q - LW'(1));
    assign press_ok  = ({1'b0, IN} < (BW+1)'(NUM_BUTTONS)) && (IN == seq_rd);
    assign rand_red  = BW'({1'b0, RAND} % (BW+1)'(NUM_BUTTONS));

    simon_seq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BW),
        .AW    (MW)
    ) u_seq_mem (
        .clk_i   (CLK),
        .we_i    (seq_we),
        .waddr_i (len_q[MW-1:0]),
        .wdata_i (rand_red),
        .raddr_i (idx_q[MW-1:0]),
        .rdata_o (seq_rd)
    );

    // Next-state and datapath decisions for the game FSM.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        go_d       = 1'b0;
        win_d      = win_q;
        lose_d     = lose_q;
        hs_d       = hs_q;
        hs_score_d = hs_score_q;
        seq_we     = 1'b0;
        score      = len_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    hs_d    = 1'b0;
                    len_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                seq_we  = 1'b1;
                len_d   = len_q + LW'(1);
                idx_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (pulse_v) begin
                    if (cnt_q == CW'(ON_PULSES - 1)) begin
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                if (pulse_v) begin
                    if (cnt_q == CW'(GAP_PULSES - 1)) begin
                        if (last_step) begin
                            idx_d   = '0;
                            state_d = S_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + LW'(1);
                            state_d = S_SHOW;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WAIT_IN: begin
                if (IN_VALID) begin
                    if (!press_ok) begin
                        state_d = S_LOSE;
                    end else if (!last_step) begin
                        idx_d = idx_q + LW'(1);
`ifdef SIMON_INPUT_TIMEOUT_EN
                        go_d  = 1'b1;
                        cnt_d = '0;
`endif
                    end else if (len_q == LW'(DEPTH)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_ADD;
                    end
                end
`ifdef SIMON_INPUT_TIMEOUT_EN
                else if (pulse_v) begin
                    if (cnt_q == CW'(TIMEOUT_PULSES - 1)) begin
                        state_d = S_LOSE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
            end
            S_WIN, S_LOSE: begin
                score  = (state_q == S_WIN) ? len_q : len_q - LW'(1);
                win_d  = (state_q == S_WIN);
                lose_d = (state_q == S_LOSE);
                if (score > hs_score_q) begin
                    hs_score_d = score;
                    hs_d       = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state entry restarts the pulse count; timed states also
        // kick the external timer in their first cycle.
        if (state_d != state_q) begin
            cnt_d = '0;
            go_d  = (state_d == S_SHOW) || (state_d == S_GAP);
`ifdef SIMON_INPUT_TIMEOUT_EN
            if (state_d == S_WAIT_IN) begin
                go_d = 1'b1;
            end
`endif
        end
    end

    // FSM and game registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            go_q       <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            hs_q       <= 1'b0;
            hs_score_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            go_q       <= go_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            hs_q       <= hs_d;
            hs_score_q <= hs_score_d;
        end
    end

    // Remember the lamp shown last so OUT stays stable while dark.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_hold_q <= '0;
        end else if (state_q == S_SHOW) begin
            out_hold_q <= seq_rd;
        end
    end

    assign OUT      = (state_q == S_SHOW) ? seq_rd : out_hold_q;
    assign OUT_ENA  = (state_q == S_SHOW);
    assign TIMER_GO = go_q;
    assign LEVEL    = len_q;
    assign HS_SCORE = hs_score_q;
    assign HS       = hs_q;
    assign WIN      = win_q;
    assign LOSE     = lose_q;
    assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_simon_core.sv
// Randomised self-checking bench for simon_core. The bench plays whole games
// as a player would: it chooses RAND values, watches playback, and presses.
module tb_simon_core;

    localparam int unsigned NB   = 5;
    localparam int unsigned DP   = 4;
    localparam int unsigned ONP  = 2;
    localparam int unsigned GAPP = 1;
    localparam int unsigned TOP  = 8;
    localparam int unsigned BW   = 3;
    localparam int unsigned LW   = 3;

`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST, START, IN_VALID, TIMER_PULSE;
    logic [BW-1:0] RAND, IN, OUT;
    logic          TIMER_GO, OUT_ENA, HS, WIN, LOSE, BUSY;
    logic [LW-1:0] LEVEL, HS_SCORE;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          exp_seq[$];
    int          best = 0;

    simon_core #(
        .NUM_BUTTONS    (NB),
        .DEPTH          (DP),
        .ON_PULSES      (ONP),
        .GAP_PULSES     (GAPP),
        .TIMEOUT_PULSES (TOP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .RAND        (RAND),
        .IN          (IN),
        .IN_VALID    (IN_VALID),
        .TIMER_PULSE (TIMER_PULSE),
        .TIMER_GO    (TIMER_GO),
        .OUT         (OUT),
        .OUT_ENA     (OUT_ENA),
        .LEVEL       (LEVEL),
        .HS_SCORE    (HS_SCORE),
        .HS          (HS),
        .WIN         (WIN),
        .LOSE        (LOSE),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic logic rnd_pulse(input int guard);
        return ($urandom_range(2) == 0) || (guard > 40);
    endfunction

    // Inputs the engine must ignore during playback.
    task automatic noise();
        IN       = BW'($urandom);
        IN_VALID = ($urandom_range(2) == 0);
        START    = ($urandom_range(3) == 0);
        RAND     = BW'($urandom);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out"},      OUT, 0);
        check({tag, "_out_ena"},  OUT_ENA, 0);
        check({tag, "_timer_go"}, TIMER_GO, 0);
        check({tag, "_level"},    LEVEL, 0);
        check({tag, "_hs_score"}, HS_SCORE, 0);
        check({tag, "_hs"},       HS, 0);
        check({tag, "_win"},      WIN, 0);
        check({tag, "_lose"},     LOSE, 0);
        check({tag, "_busy"},     BUSY, 0);
    endtask

    task automatic check_end(input bit won, input bit new_hs, input int lvl);
        check("end_busy",     BUSY, 0);
        check("end_win",      WIN, won);
        check("end_lose",     LOSE, !won);
        check("end_hs",       HS, new_hs);
        check("end_hs_score", HS_SCORE, best);
        check("end_level",    LEVEL, lvl);
        check("end_lamp",     OUT_ENA, 0);
    endtask

    // Called at the negedge of the one-cycle WIN/LOSE state.
    task automatic finish_game(input bit won);
        int lvl;
        int score;
        bit nh;
        lvl   = exp_seq.size();
        score = won ? lvl : lvl - 1;
        check("fin_busy", BUSY, 1);
        check("fin_flag", won ? WIN : LOSE, 0);
        START       = 1'b0;
        IN_VALID    = 1'b0;
        TIMER_PULSE = rnd_pulse(0);
        nh = (score > best);
        if (nh) best = score;
        @(negedge CLK);
        check_end(won, nh, lvl);
        repeat (2) begin
            IN_VALID    = $urandom_range(1);
            IN          = BW'($urandom);
            TIMER_PULSE = rnd_pulse(0);
            @(negedge CLK);
        end
        check_end(won, nh, lvl);
    endtask

    // Issue START from IDLE; returns at the negedge of the first lit cycle.
    task automatic start_game();
        int r;
        r = $urandom_range(7);
        exp_seq.delete();
        RAND        = BW'(r);
        START       = 1'b1;
        IN_VALID    = $urandom_range(1);
        IN          = BW'($urandom);
        TIMER_PULSE = rnd_pulse(0);
        @(negedge CLK);
        START = $urandom_range(1);
        check("add_busy",  BUSY, 1);
        check("add_dark",  OUT_ENA, 0);
        check("add_level", LEVEL, 0);
        check("add_clear", {WIN, LOSE, HS}, 0);
        exp_seq.push_back(r % NB);
        @(negedge CLK);
        check("start_latency", OUT_ENA, 1);
        check("start_level",   LEVEL, 1);
    endtask

    // Observe the whole playback; returns at the first WAIT_IN negedge.
    task automatic playback();
        int len;
        len = exp_seq.size();
        for (int k = 0; k < len; k++) begin
            int cnt;
            int guard;
            bit first;
            check("lamp_on",  OUT_ENA, 1);
            check("lamp_idx", OUT, exp_seq[k]);
            check("show_go",  TIMER_GO, 1);
            cnt = 0; guard = 0; first = 1'b1;
            while (cnt < ONP) begin
                noise();
                TIMER_PULSE = rnd_pulse(guard++);
                if (TIMER_PULSE && !first) cnt++;
                first = 1'b0;
                @(negedge CLK);
                if (cnt < ONP) begin
                    check("lamp_hold",    OUT_ENA, 1);
                    check("lamp_idx_hold", OUT, exp_seq[k]);
                    check("show_go_low",  TIMER_GO, 0);
                end
            end
            check("gap_dark",     OUT_ENA, 0);
            check("gap_go",       TIMER_GO, 1);
            check("gap_out_hold", OUT, exp_seq[k]);
            cnt = 0; guard = 0; first = 1'b1;
            while (cnt < GAPP) begin
                noise();
                TIMER_PULSE = rnd_pulse(guard++);
                if (TIMER_PULSE && !first) cnt++;
                first = 1'b0;
                @(negedge CLK);
                if (cnt < GAPP) begin
                    check("gap_hold",   OUT_ENA, 0);
                    check("gap_go_low", TIMER_GO, 0);
                end
            end
        end
    endtask

    // Player turn. wrong_at: index pressed wrongly (-1 none). tmode (first
    // press only): 1 = never press, 2 = press on the terminal timeout pulse.
    // res: 0 lost, 1 next round started (at first lit negedge), 2 won.
    task automatic respond(input int wrong_at, input int tmode, output int res);
        int len;
        int r;
        bit go_now;
        len    = exp_seq.size();
        r      = 0;
        go_now = TO_EN;
        res    = 1;
        check("wait_level",    LEVEL, len);
        check("wait_out_hold", OUT, exp_seq[len-1]);
        for (int i = 0; i < len; i++) begin
            int val;
            int vp;
            int guard;
            int waits;
            bit p;
            bit press_now;
            val = exp_seq[i]; vp = 0; guard = 0;
            waits = $urandom_range(3);
            forever begin
                check("wait_dark", OUT_ENA, 0);
                check("wait_busy", BUSY, 1);
                check("wait_go",   TIMER_GO, go_now);
                p = rnd_pulse(guard);
                guard++;
                if (p && !go_now) vp++;
                go_now      = 1'b0;
                TIMER_PULSE = p;
                START       = $urandom_range(1);
                RAND        = BW'($urandom);
                IN          = BW'($urandom);
                if (tmode != 0 && i == 0) press_now = (tmode == 2 && vp == TOP);
                else press_now = (guard > waits);
                if (press_now) break;
                IN_VALID = 1'b0;
                if (tmode == 1 && i == 0 && vp == TOP) begin
                    @(negedge CLK);
                    finish_game(1'b0);
                    res = 0;
                    return;
                end
                @(negedge CLK);
            end
            if (i == wrong_at) begin
                do val = $urandom_range(7); while (val == exp_seq[i]);
            end
            IN_VALID = 1'b1;
            IN       = BW'(val);
            if (i == len - 1 && i != wrong_at && len < DP) begin
                r    = $urandom_range(7);
                RAND = BW'(r);
            end
            @(negedge CLK);
            IN_VALID = 1'b0;
            START    = 1'b0;
            if (i == wrong_at) begin
                finish_game(1'b0);
                res = 0;
                return;
            end
            go_now = TO_EN;
        end
        if (len == DP) begin
            finish_game(1'b1);
            res = 2;
            return;
        end
        check("add2_dark",  OUT_ENA, 0);
        check("add2_busy",  BUSY, 1);
        check("add2_level", LEVEL, len);
        exp_seq.push_back(r % NB);
        TIMER_PULSE = rnd_pulse(0);
        @(negedge CLK);
        check("round_latency", OUT_ENA, 1);
        check("round_level",   LEVEL, len + 1);
    endtask

    // lose_round: round in which press wrong_idx is wrong (0 = play to win).
    task automatic play_game(input int lose_round, input int wrong_idx, input int tmode);
        int res;
        int tm;
        res = 1;
        tm  = tmode;
        start_game();
        while (res == 1) begin
            playback();
            respond((exp_seq.size() == lose_round) ? wrong_idx : -1, tm, res);
            tm = 0;
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN = '0; RAND = '0; TIMER_PULSE = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset("rst");
        RST = 1'b0;
        repeat (10) begin
            TIMER_PULSE = rnd_pulse(0);
            IN_VALID    = $urandom_range(1);
            IN          = BW'($urandom);
            @(negedge CLK);
        end
        check_reset("idle");

        play_game(3, 2, 0);   // score 2: new high score
        play_game(2, 1, 0);   // score 1: no new high score
        play_game(0, 0, 0);   // full win: score DP

        for (int g = 0; g < 12; g++) begin
            int lr;
            lr = $urandom_range(DP);
            play_game(lr, (lr == 0) ? 0 : $urandom_range(lr - 1), 0);
        end

`ifdef SIMON_INPUT_TIMEOUT_EN
        play_game(0, 0, 1);   // no press: timeout loss in round 1
        play_game(2, 0, 2);   // press on terminal pulse survives, lose round 2
`endif

        // Mid-game reset drops everything, including the high score.
        start_game();
        repeat (3) begin
            noise();
            TIMER_PULSE = rnd_pulse(0);
            @(negedge CLK);
        end
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        check_reset("midrst");
        RST  = 1'b0;
        best = 0;
        @(negedge CLK);
        check_reset("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
